// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises configuration words onto the head of a
// configuration flip-flop chain. Optionally recirculates the chain once and
// compares CRC-16 signatures of the written and returned bit streams before
// reporting cfg_done.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8,
  parameter bit VERIFY    = 1'b1,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              chain_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              cfg_done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int              IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [15:0]      CRC_INIT = 16'hFFFF;
  localparam logic [15:0]      CRC_POLY = 16'h1021;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  // One bit-serial CRC-16 step, feedback taken from the MSB.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

  state_t             state_r;
  logic [WORD_W-1:0]  buf_r;
  logic               buf_valid_r;
  logic [IDX_W-1:0]   idx_r;
  logic [CNT_W-1:0]   bit_count_r;
  logic [15:0]        tx_crc_r;
  logic [15:0]        rx_crc_r;
  logic               busy_r;
  logic               cfg_done_r;
  logic               error_r;

  // Sequencer: word buffering, bit counting, CRC accumulation and status flags.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_r     <= ST_IDLE;
      buf_r       <= '0;
      buf_valid_r <= 1'b0;
      idx_r       <= '0;
      bit_count_r <= '0;
      tx_crc_r    <= CRC_INIT;
      rx_crc_r    <= CRC_INIT;
      busy_r      <= 1'b0;
      cfg_done_r  <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_r     <= ST_LOAD;
            buf_valid_r <= 1'b0;
            idx_r       <= '0;
            bit_count_r <= '0;
            tx_crc_r    <= CRC_INIT;
            rx_crc_r    <= CRC_INIT;
            busy_r      <= 1'b1;
            cfg_done_r  <= 1'b0;
            error_r     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (buf_valid_r) begin
            tx_crc_r <= crc16_step(tx_crc_r, buf_r[idx_r]);
            idx_r    <= idx_r + IDX_W'(1);
            // Final bit of the word, or final bit of the chain: drop the rest.
            if ((idx_r == LAST_IDX) || (bit_count_r == LAST_BIT)) begin
              buf_valid_r <= 1'b0;
            end
            if (bit_count_r == LAST_BIT) begin
              bit_count_r <= '0;
              if (VERIFY) begin
                state_r <= ST_VERIFY;
              end else begin
                state_r    <= ST_DONE;
                busy_r     <= 1'b0;
                cfg_done_r <= 1'b1;
              end
            end else begin
              bit_count_r <= bit_count_r + CNT_W'(1);
            end
          end else if (s_valid && s_ready) begin
            buf_r       <= s_data;
            buf_valid_r <= 1'b1;
            idx_r       <= '0;
          end
        end
        ST_VERIFY: begin
          rx_crc_r    <= crc16_step(rx_crc_r, ccff_tail);
          bit_count_r <= bit_count_r + CNT_W'(1);
          if (bit_count_r == LAST_BIT) begin
            state_r <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          busy_r <= 1'b0;
          if (rx_crc_r == tx_crc_r) begin
            state_r    <= ST_DONE;
            cfg_done_r <= 1'b1;
          end else begin
            state_r <= ST_ERR;
            error_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          buf_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          cfg_done_r  <= 1'b0;
          error_r     <= 1'b0;
        end
      endcase
    end
  end

  // Chain-side strobes: shift only while a buffered bit or recirculated bit is available.
  always_comb begin
    s_ready   = 1'b0;
    chain_en  = 1'b0;
    ccff_head = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (buf_valid_r) begin
          chain_en  = 1'b1;
          ccff_head = buf_r[idx_r];
        end else begin
          s_ready = (bit_count_r < FULL_CNT);
        end
      end
      ST_VERIFY: begin
        chain_en  = 1'b1;
        ccff_head = ccff_tail;
      end
      default: begin
        s_ready   = 1'b0;
        chain_en  = 1'b0;
        ccff_head = 1'b0;
      end
    endcase
  end

  assign busy      = busy_r;
  assign cfg_done  = cfg_done_r;
  assign error     = error_r;
  assign bit_count = bit_count_r;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: four instances (8/16/12-flop chains with
// verification, 8-flop without) each attached to a behavioural shift chain.
// Expected per-cycle behaviour comes from a transaction-level timeline model.
`timescale 1ns/1ps
module tb_ccff_chain_loader;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a    [NI];
  logic       start_a  [NI];
  logic       valid_a  [NI];
  logic [7:0] data_a   [NI];
  logic       sready_a [NI];
  logic       head_a   [NI];
  logic       chen_a   [NI];
  logic       tail_a   [NI];
  logic       busy_a   [NI];
  logic       done_a   [NI];
  logic       err_a    [NI];
  logic [15:0] ch      [NI];
  logic [15:0] flip_a  [NI];
  logic [3:0] bc0, bc2, bc3;
  logic [4:0] bc1;

  logic [7:0] stim_w   [4];
  int         stim_gap [4];
  int n_checks = 0;
  int n_fail   = 0;

  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .VERIFY(1'b1)) u_l8 (
    .prog_clk(clk), .prog_reset(rst_a[0]), .start(start_a[0]), .s_data(data_a[0]),
    .s_valid(valid_a[0]), .s_ready(sready_a[0]), .ccff_head(head_a[0]), .chain_en(chen_a[0]),
    .ccff_tail(tail_a[0]), .busy(busy_a[0]), .cfg_done(done_a[0]), .error(err_a[0]), .bit_count(bc0));
  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .VERIFY(1'b1)) u_l16 (
    .prog_clk(clk), .prog_reset(rst_a[1]), .start(start_a[1]), .s_data(data_a[1]),
    .s_valid(valid_a[1]), .s_ready(sready_a[1]), .ccff_head(head_a[1]), .chain_en(chen_a[1]),
    .ccff_tail(tail_a[1]), .busy(busy_a[1]), .cfg_done(done_a[1]), .error(err_a[1]), .bit_count(bc1));
  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8), .VERIFY(1'b1)) u_l12 (
    .prog_clk(clk), .prog_reset(rst_a[2]), .start(start_a[2]), .s_data(data_a[2]),
    .s_valid(valid_a[2]), .s_ready(sready_a[2]), .ccff_head(head_a[2]), .chain_en(chen_a[2]),
    .ccff_tail(tail_a[2]), .busy(busy_a[2]), .cfg_done(done_a[2]), .error(err_a[2]), .bit_count(bc2));
  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .VERIFY(1'b0)) u_nv8 (
    .prog_clk(clk), .prog_reset(rst_a[3]), .start(start_a[3]), .s_data(data_a[3]),
    .s_valid(valid_a[3]), .s_ready(sready_a[3]), .ccff_head(head_a[3]), .chain_en(chen_a[3]),
    .ccff_tail(tail_a[3]), .busy(busy_a[3]), .cfg_done(done_a[3]), .error(err_a[3]), .bit_count(bc3));

  function automatic int len_of(input int k);
    case (k)
      0: return 8;
      1: return 16;
      2: return 12;
      default: return 8;
    endcase
  endfunction

  function automatic int bc_of(input int k);
    case (k)
      0: return int'(bc0);
      1: return int'(bc1);
      2: return int'(bc2);
      default: return int'(bc3);
    endcase
  endfunction

  // Behavioural chains: position 0 is next to ccff_head, position LEN-1 drives ccff_tail.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (chen_a[k]) ch[k] <= {ch[k][14:0], head_a[k]} ^ flip_a[k];
      else           ch[k] <= ch[k] ^ flip_a[k];
    end
  end

  // Tail of each chain depends on that chain's length.
  always_comb begin
    for (int k = 0; k < NI; k++) tail_a[k] = ch[k][len_of(k) - 1];
  end

  // Runs one full load on instance k with words stim_w[0..nw-1] and gaps stim_gap.
  // Timeline model: word w accepted at h drives its bits on h+1..h+n; the last
  // bit L is followed by LEN verify cycles, one check cycle, then DONE/ERR.
  task automatic run_load(input int k, input int nw, input int flip_at, input bit start_mid,
                          input bit verify_on, input bit exp_ok, input string tag);
    int len, c, w, gap_left, full_until, h_cur, shifted, L, done_c, dut_hs, nbits, e_bc;
    bit all_hs, ld, vf, ck, dn, full;
    logic [7:0] cur, tw;
    logic e_rdy, e_en, e_head, e_busy, e_done, e_err;
    logic [15:0] exp_ch, mask;
    len = len_of(k);
    @(negedge clk);
    start_a[k] = 1'b1;
    valid_a[k] = 1'b0;
    w = 0; gap_left = stim_gap[0]; full_until = 0; h_cur = 0; shifted = 0;
    L = -1; done_c = 1000000; dut_hs = 0; cur = 8'h00;
    c = 1;
    while (c < 600) begin
      @(negedge clk);
      all_hs = (w == nw);
      full   = (c <= full_until);
      ld     = !all_hs || full;
      vf     = verify_on && (L >= 0) && (c > L) && (c <= L + len);
      ck     = verify_on && (L >= 0) && (c == L + len + 1);
      dn     = (L >= 0) && (c >= done_c);
      start_a[k] = start_mid && (L >= 0) && (c == L + 3);
      valid_a[k] = all_hs ? 1'b1 : (gap_left == 0);
      data_a[k]  = (!all_hs && gap_left == 0) ? stim_w[w] : 8'($urandom);
      flip_a[k]  = (vf && (c - L == flip_at)) ? 16'h0010 : 16'h0000;
      e_rdy  = ld && !full;
      e_en   = (ld && full) || vf;
      e_busy = ld || vf || ck;
      e_done = dn && exp_ok;
      e_err  = dn && !exp_ok;
      e_bc   = ld ? shifted : (vf ? (c - L - 1) : -1);
      #1;
      if (ld && full) e_head = cur[c - h_cur - 1];
      else if (vf)    e_head = tail_a[k];
      else            e_head = 1'b0;
      n_checks++;
      if (sready_a[k] !== e_rdy) begin n_fail++;
        $display("FAIL %s s_ready cyc %0d: got %b exp %b", tag, c, sready_a[k], e_rdy); end
      n_checks++;
      if (chen_a[k] !== e_en) begin n_fail++;
        $display("FAIL %s chain_en cyc %0d: got %b exp %b", tag, c, chen_a[k], e_en); end
      n_checks++;
      if (head_a[k] !== e_head) begin n_fail++;
        $display("FAIL %s ccff_head cyc %0d: got %b exp %b", tag, c, head_a[k], e_head); end
      n_checks++;
      if (busy_a[k] !== e_busy) begin n_fail++;
        $display("FAIL %s busy cyc %0d: got %b exp %b", tag, c, busy_a[k], e_busy); end
      n_checks++;
      if (done_a[k] !== e_done) begin n_fail++;
        $display("FAIL %s cfg_done cyc %0d: got %b exp %b", tag, c, done_a[k], e_done); end
      n_checks++;
      if (err_a[k] !== e_err) begin n_fail++;
        $display("FAIL %s error cyc %0d: got %b exp %b", tag, c, err_a[k], e_err); end
      if (e_bc >= 0) begin
        n_checks++;
        if (bc_of(k) != e_bc) begin n_fail++;
          $display("FAIL %s bit_count cyc %0d: got %0d exp %0d", tag, c, bc_of(k), e_bc); end
      end
      if (valid_a[k] && sready_a[k]) dut_hs++;
      if (ld && full) shifted++;
      if (!all_hs && valid_a[k] && e_rdy) begin
        h_cur = c;
        cur   = stim_w[w];
        nbits = (len - 8 * w < 8) ? (len - 8 * w) : 8;
        full_until = c + nbits;
        w++;
        if (w < nw) gap_left = stim_gap[w];
        if (w == nw) begin
          L = full_until;
          done_c = verify_on ? (L + len + 2) : (L + 1);
        end
      end else if (!valid_a[k] && e_rdy && gap_left > 0) begin
        gap_left--;
      end
      if (c >= done_c + 2) break;
      c++;
    end
    start_a[k] = 1'b0;
    valid_a[k] = 1'b0;
    flip_a[k]  = 16'h0000;
    n_checks++;
    if (!(L >= 0 && c >= done_c + 2)) begin n_fail++;
      $display("FAIL %s timeout: reached cyc %0d, need done by %0d", tag, c, done_c); end
    n_checks++;
    if (dut_hs != nw) begin n_fail++;
      $display("FAIL %s handshakes: got %0d exp %0d", tag, dut_hs, nw); end
    if (exp_ok) begin
      mask = 16'hFFFF >> (16 - len);
      exp_ch = 16'h0000;
      for (int j = 0; j < len; j++) begin
        tw = stim_w[j / 8];
        exp_ch[len - 1 - j] = tw[j % 8];
      end
      n_checks++;
      if ((ch[k] & mask) !== exp_ch) begin n_fail++;
        $display("FAIL %s chain contents: got %h exp %h", tag, ch[k] & mask, exp_ch); end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if ({sready_a[k], chen_a[k], head_a[k], busy_a[k], done_a[k], err_a[k]} !== 6'b000000
          || bc_of(k) != 0) begin
        n_fail++;
        $display("FAIL reset inst %0d: rdy/en/head/busy/done/err=%b%b%b%b%b%b bc=%0d exp all 0",
                 k, sready_a[k], chen_a[k], head_a[k], busy_a[k], done_a[k], err_a[k], bc_of(k));
      end
    end
    for (int k = 0; k < NI; k++) rst_a[k] = 1'b0;
  endtask

  task automatic test_basic_a5();
    stim_w[0] = 8'hA5; stim_gap[0] = 0;
    run_load(0, 1, 0, 1'b0, 1'b1, 1'b1, "basic_a5");
  endtask

  task automatic test_stall();
    stim_w[0] = 8'h3C; stim_w[1] = 8'($urandom);
    stim_gap[0] = 0; stim_gap[1] = 5;
    run_load(1, 2, 0, 1'b0, 1'b1, 1'b1, "stall");
  endtask

  task automatic test_partial_word();
    stim_w[0] = 8'hFF; stim_w[1] = 8'h5A;
    stim_gap[0] = 0; stim_gap[1] = 0;
    run_load(2, 2, 0, 1'b0, 1'b1, 1'b1, "partial");
  endtask

  task automatic test_fault();
    stim_w[0] = 8'($urandom); stim_gap[0] = 1;
    run_load(0, 1, 1, 1'b0, 1'b1, 1'b0, "fault");
    stim_w[0] = 8'($urandom); stim_gap[0] = 0;
    run_load(0, 1, 0, 1'b0, 1'b1, 1'b1, "after_fault");
  endtask

  task automatic test_reset_mid_load();
    int cnt;
    cnt = 0;
    @(negedge clk);
    start_a[0] = 1'b1; valid_a[0] = 1'b1; data_a[0] = 8'hA5;
    for (int i = 0; i < 30 && cnt < 5; i++) begin
      @(negedge clk);
      start_a[0] = 1'b0;
      #1;
      if (chen_a[0]) cnt++;
    end
    n_checks++;
    if (cnt != 5) begin n_fail++;
      $display("FAIL mid_reset shifted bits before reset: got %0d exp 5", cnt); end
    rst_a[0] = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if ({sready_a[0], chen_a[0], head_a[0], busy_a[0], done_a[0], err_a[0]} !== 6'b000000
        || bc_of(0) != 0) begin
      n_fail++;
      $display("FAIL mid_reset outputs: rdy/en/head/busy/done/err=%b%b%b%b%b%b bc=%0d exp all 0",
               sready_a[0], chen_a[0], head_a[0], busy_a[0], done_a[0], err_a[0], bc_of(0));
    end
    rst_a[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({sready_a[0], chen_a[0], busy_a[0]} !== 3'b000) begin n_fail++;
        $display("FAIL mid_reset idle hold cyc %0d: rdy/en/busy=%b%b%b exp 000",
                 i, sready_a[0], chen_a[0], busy_a[0]); end
    end
    valid_a[0] = 1'b0;
  endtask

  task automatic test_start_in_verify();
    stim_w[0] = 8'($urandom); stim_gap[0] = 0;
    run_load(0, 1, 0, 1'b1, 1'b1, 1'b1, "start_in_verify");
  endtask

  task automatic test_no_verify();
    stim_w[0] = 8'h81; stim_gap[0] = 0;
    run_load(3, 1, 0, 1'b0, 1'b0, 1'b1, "no_verify");
  endtask

  task automatic test_random();
    int k, nw;
    for (int r = 0; r < 8; r++) begin
      k  = r % NI;
      nw = (len_of(k) + 7) / 8;
      for (int i = 0; i < 4; i++) begin
        stim_w[i]   = 8'($urandom);
        stim_gap[i] = int'($urandom_range(0, 3));
      end
      run_load(k, nw, 0, 1'b0, (k != 3), 1'b1, "random");
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_a[k] = 1'b1; start_a[k] = 1'b0; valid_a[k] = 1'b0;
      data_a[k] = 8'h00; flip_a[k] = 16'h0000;
    end
    test_reset();
    test_basic_a5();
    test_stall();
    test_partial_word();
    test_fault();
    test_reset_mid_load();
    test_start_in_verify();
    test_no_verify();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
